// File: rtl/program_loader_pkg.sv
// Shared K16 definitions: loader state encoding, default SYNC byte and the
// instruction/program-address widths also used by the processor.
package k16_defs;

    localparam logic [7:0] SYNC_DEFAULT    = 8'hA5;
    localparam int         INSTR_W         = 24;
    localparam int         PADDR_W_DEFAULT = 16;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LEN_H = 4'd1,
        ST_LEN_L = 4'd2,
        ST_B2    = 4'd3,
        ST_B1    = 4'd4,
        ST_B0    = 4'd5,
        ST_WRITE = 4'd6,
        ST_CHK   = 4'd7,
        ST_RUN   = 4'd8,
        ST_ERROR = 4'd9
    } loader_state_t;

    // True for every state between an accepted SYNC and the checksum verdict.
    function automatic logic is_frame_state(input loader_state_t s);
        case (s)
            ST_LEN_H, ST_LEN_L, ST_B2, ST_B1, ST_B0, ST_WRITE, ST_CHK: is_frame_state = 1'b1;
            default:                                                   is_frame_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream plus program-memory write port of the boot loader.
interface program_loader_if #(parameter int PADDR_W = k16_defs::PADDR_W_DEFAULT);

    logic [7:0]                   in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [PADDR_W-1:0]           pm_addr;
    logic [k16_defs::INSTR_W-1:0] pm_wdata;
    logic                         pm_we;

    modport master (
        output in_data, in_valid,
        input  in_ready, pm_addr, pm_wdata, pm_we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, pm_addr, pm_wdata, pm_we
    );

endinterface

// File: rtl/program_loader_word_packer.sv
// Packs bytes MSB-first into a 24-bit word; word_ready pulses for one cycle
// after the third byte has been shifted in.
module pm_word_packer
    import k16_defs::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_ready
);

    logic [1:0] cnt_r;

    // Byte shift register, byte counter and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word       <= {INSTR_W{1'b0}};
            cnt_r      <= 2'd0;
            word_ready <= 1'b0;
        end else if (clr) begin
            cnt_r      <= 2'd0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= shift_en && (cnt_r == 2'd2);
            if (shift_en) begin
                word  <= {word[INSTR_W-9:0], byte_in};
                cnt_r <= (cnt_r == 2'd2) ? 2'd0 : cnt_r + 2'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// K16 boot loader: parses SYNC/LEN/words/CHK frames, writes words to program
// memory from address 0 and holds the processor in reset until a good checksum.
module program_loader
    import k16_defs::*;
#(
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         PADDR_W = PADDR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus,
    output logic             cpu_rst,
    output logic             loading,
    output logic             done,
    output logic             err
);

    loader_state_t      state_r, state_s;
    logic               in_ready_r;
    logic [15:0]        len_r;
    logic [PADDR_W-1:0] idx_r;
    logic [PADDR_W-1:0] pm_addr_r;
    logic [7:0]         xor_r;
    logic               accept_s, start_s, shift_s, last_s;
    logic [INSTR_W-1:0] pk_word;
    logic               pk_ready;

    assign accept_s = bus.in_valid && in_ready_r;
    assign start_s  = (state_s == ST_LEN_H) && (state_r != ST_LEN_H);
    assign shift_s  = accept_s && ((state_r == ST_B2) || (state_r == ST_B1) || (state_r == ST_B0));
    assign last_s   = (idx_r == PADDR_W'(len_r - 16'd1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Next-state logic; SYNC restarts only outside a frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (accept_s && (bus.in_data == SYNC)) state_s = ST_LEN_H;
                else                                   state_s = state_r;
            end
            ST_LEN_H: begin
                if (accept_s) state_s = ST_LEN_L;
                else          state_s = state_r;
            end
            ST_LEN_L: begin
                if (!accept_s)                                  state_s = state_r;
                else if ({len_r[15:8], bus.in_data} == 16'd0) state_s = ST_CHK;
                else                                            state_s = ST_B2;
            end
            ST_B2: begin
                if (accept_s) state_s = ST_B1;
                else          state_s = state_r;
            end
            ST_B1: begin
                if (accept_s) state_s = ST_B0;
                else          state_s = state_r;
            end
            ST_B0: begin
                if (accept_s) state_s = ST_WRITE;
                else          state_s = state_r;
            end
            ST_WRITE: begin
                if (last_s) state_s = ST_CHK;
                else        state_s = ST_B2;
            end
            ST_CHK: begin
                if (!accept_s)                  state_s = state_r;
                else if (bus.in_data == xor_r) state_s = ST_RUN;
                else                            state_s = ST_ERROR;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            cpu_rst    <= 1'b1;
            loading    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            in_ready_r <= (state_s != ST_WRITE);
            cpu_rst    <= (state_s != ST_RUN);
            loading    <= is_frame_state(state_s);
            done       <= (state_s == ST_RUN);
            err        <= (state_s == ST_ERROR);
        end
    end

    // Length capture, running XOR, word index and held write address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r     <= 16'd0;
            idx_r     <= {PADDR_W{1'b0}};
            xor_r     <= 8'd0;
            pm_addr_r <= {PADDR_W{1'b0}};
        end else if (start_s) begin
            idx_r <= {PADDR_W{1'b0}};
            xor_r <= 8'd0;
        end else begin
            if (accept_s && (state_r == ST_LEN_H)) len_r[15:8] <= bus.in_data;
            if (accept_s && (state_r == ST_LEN_L)) len_r[7:0]  <= bus.in_data;
            if (accept_s && is_frame_state(state_r) && (state_r != ST_CHK))
                xor_r <= xor_r ^ bus.in_data;
            if (accept_s && (state_r == ST_B0)) pm_addr_r <= idx_r;
            if (state_r == ST_WRITE) idx_r <= idx_r + {{(PADDR_W-1){1'b0}}, 1'b1};
        end
    end

    pm_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_s),
        .shift_en   (shift_s),
        .byte_in    (bus.in_data),
        .word       (pk_word),
        .word_ready (pk_ready)
    );

    assign bus.in_ready = in_ready_r;
    assign bus.pm_addr  = pm_addr_r;
    assign bus.pm_wdata = pk_word;
    assign bus.pm_we    = pk_ready;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame vectors, reset/reload corner
// cases and randomized frames against a frame-level reference model.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_rst, loading, done, err;

    program_loader_if #(.PADDR_W(16)) bus ();

    program_loader #(.SYNC(8'hA5), .PADDR_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .loading (loading),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [7:0]  frame_q[$];
    logic [39:0] exp_q[$];
    logic [39:0] wq[$];
    logic [23:0] mem_exp[int];
    logic [23:0] mem_dut[int];

    typedef struct {
        logic [95:0] bytes;
        int          n;
        int          nw;
        logic [23:0] w0;
        logic [23:0] w1;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Write-port monitor: in_ready must drop exactly in write cycles.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.in_ready !== !bus.pm_we) begin
                failures++;
                $display("FAIL ready_vs_we got in_ready=%b pm_we=%b expected in_ready=!pm_we",
                         bus.in_ready, bus.pm_we);
            end
            if (bus.pm_we === 1'b1) begin
                wq.push_back({bus.pm_addr, bus.pm_wdata});
                mem_dut[int'(bus.pm_addr)] = bus.pm_wdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout got=0 expected=1 after 64 cycles");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        mon_en       = 1'b0;
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_pm_addr",  bus.pm_addr,  16'h0);
        check("rst_pm_wdata", bus.pm_wdata, 24'h0);
        check("rst_pm_we",    bus.pm_we,    1'b0);
        check("rst_cpu_rst",  cpu_rst,      1'b1);
        check("rst_loading",  loading,      1'b0);
        check("rst_done",     done,         1'b0);
        check("rst_err",      err,          1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    // Reference model: build a frame from random words and predict its writes.
    task automatic build_random(input int nwords, input bit corrupt);
        logic [15:0] len;
        logic [7:0]  x, b;
        logic [23:0] w;
        frame_q.delete();
        exp_q.delete();
        len = nwords[15:0];
        frame_q.push_back(8'hA5);
        frame_q.push_back(len[15:8]);
        frame_q.push_back(len[7:0]);
        x = len[15:8] ^ len[7:0];
        for (int i = 0; i < nwords; i++) begin
            w = 24'h0;
            for (int k = 0; k < 3; k++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
                w = {w[15:0], b};
                frame_q.push_back(b);
                x = x ^ b;
            end
            exp_q.push_back({i[15:0], w});
            mem_exp[i] = w;
        end
        if (corrupt) x = x ^ (8'h01 << $urandom_range(0, 7));
        frame_q.push_back(x);
    endtask

    task automatic play_frame(input bit exp_done, input bit exp_err, input bit gaps,
                              input bit chk_first, input string nm);
        wq.delete();
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], gaps);
            if (i == 0 && chk_first) begin
                check({nm, "_start_cpu_rst"}, cpu_rst, 1'b1);
                check({nm, "_start_done"},    done,    1'b0);
                check({nm, "_start_err"},     err,     1'b0);
                check({nm, "_start_loading"}, loading, 1'b1);
            end
        end
        check({nm, "_nwrites"}, wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
            check({nm, "_write"}, wq[i], exp_q[i]);
        check({nm, "_done"},    done,    exp_done);
        check({nm, "_err"},     err,     exp_err);
        check({nm, "_cpu_rst"}, cpu_rst, !exp_done);
        check({nm, "_loading"}, loading, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        vt[0] = '{96'hA5_00_02_20_00_05_01_00_00_26_00_00, 10, 2, 24'h200005, 24'h010000, 1'b1, 1'b0};
        vt[1] = '{96'hA5_00_02_20_00_05_01_00_00_27_00_00, 10, 2, 24'h200005, 24'h010000, 1'b0, 1'b1};
        vt[2] = '{96'hA5_00_02_20_00_05_01_00_00_26_00_00, 10, 2, 24'h200005, 24'h010000, 1'b1, 1'b0};
        vt[3] = '{96'h3C_FF_A5_00_00_00_00_00_00_00_00_00,  6, 0, 24'h0,      24'h0,      1'b1, 1'b0};
        vt[4] = '{96'hA5_00_01_A5_A5_A5_A4_00_00_00_00_00,  7, 1, 24'hA5A5A5, 24'h0,      1'b1, 1'b0};
        vt[5] = '{96'hA5_00_00_01_00_00_00_00_00_00_00_00,  4, 0, 24'h0,      24'h0,      1'b0, 1'b1};

        do_reset();

        for (int v = 0; v < 6; v++) begin
            frame_q.delete();
            exp_q.delete();
            for (int k = 0; k < vt[v].n; k++) frame_q.push_back(vt[v].bytes[95-8*k -: 8]);
            if (vt[v].nw >= 1) begin exp_q.push_back({16'd0, vt[v].w0}); mem_exp[0] = vt[v].w0; end
            if (vt[v].nw >= 2) begin exp_q.push_back({16'd1, vt[v].w1}); mem_exp[1] = vt[v].w1; end
            play_frame(vt[v].exp_done, vt[v].exp_err, 1'b0, 1'b0, $sformatf("vec%0d", v));
        end

        build_random(3, 1'b0);
        play_frame(1'b1, 1'b0, 1'b0, 1'b1, "reload_from_error");
        build_random(2, 1'b0);
        play_frame(1'b1, 1'b0, 1'b1, 1'b1, "reload_from_run");
        do_reset();

        // Reset in the middle of the second word: first word stays, nothing more written.
        frame_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wq.delete();
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
        check("midrst_first_write", wq.size(), 1);
        mem_exp[0] = 24'h112233;
        do_reset();
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        check("midrst_no_more_writes", wq.size(), 1);
        check("midrst_cpu_rst", cpu_rst, 1'b1);
        check("midrst_loading", loading, 1'b0);
        check("midrst_stale_word", mem_dut[0], 24'h112233);

        for (int f = 0; f < 25; f++) begin
            bit bad;
            bad = ($urandom_range(0, 3) == 0);
            build_random($urandom_range(0, 6), bad);
            play_frame(!bad, bad, 1'b1, 1'b1, $sformatf("rnd%0d", f));
        end
        build_random(300, 1'b0);
        play_frame(1'b1, 1'b0, 1'b0, 1'b1, "long300");

        foreach (mem_exp[a]) begin
            if (!mem_dut.exists(a)) check($sformatf("mem_missing_%0d", a), 1'b0, 1'b1);
            else                    check($sformatf("mem_%0d", a), mem_dut[a], mem_exp[a]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
